// File: rtl/rvv_inst_issue_buffer.sv
// RVV instruction issue buffer: executes vset{i}vl{i} locally to track
// vtype/vl, and queues all other vector LD/ST/ALU instructions together
// with a vtype/vl snapshot in an in-order FIFO toward the backend.
module rvv_inst_issue_buffer #(
    parameter int DEPTH = 4,
    parameter int VLEN  = 128,
    parameter int XLEN  = 32,
    parameter int VLW   = $clog2(VLEN) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     insn_valid,
    output logic                     insn_ready,
    input  logic [31:0]              insn_bits,
    input  logic [XLEN-1:0]          insn_rs1,
    input  logic [XLEN-1:0]          insn_rs2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_bits,
    output logic [XLEN-1:0]          out_rs1,
    output logic [XLEN-1:0]          out_rs2,
    output logic [31:0]              out_vtype,
    output logic [VLW-1:0]           out_vl,
    output logic                     cfg_rd_valid,
    output logic [4:0]               cfg_rd_idx,
    output logic [XLEN-1:0]          cfg_rd_data,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] VILL_VTYPE = 32'h8000_0000;
    localparam logic [6:0]  OP_LD  = 7'b0000111;
    localparam logic [6:0]  OP_ST  = 7'b0100111;
    localparam logic [6:0]  OP_ALU = 7'b1010111;

    // vtype legality: reserved bits clear, supported SEW, no reserved LMUL,
    // and fractional LMUL only where SEW fits.
    function automatic logic vtype_ok(input logic [31:0] v);
        logic [2:0] sew;
        logic [2:0] lmul;
        sew  = v[5:3];
        lmul = v[2:0];
        vtype_ok = 1'b1;
        if (v[31] || (v[30:8] != '0))              vtype_ok = 1'b0;
        if (sew > 3'd2)                            vtype_ok = 1'b0;
        if (lmul == 3'b100)                        vtype_ok = 1'b0;
        if ((lmul == 3'b110) && (sew != 3'd0))     vtype_ok = 1'b0;
        if ((lmul == 3'b111) && (sew == 3'd2))     vtype_ok = 1'b0;
    endfunction

    // VLMAX = (VLEN/SEW) * LMUL, evaluated as shifts of VLEN/8.
    function automatic logic [VLW-1:0] vlmax_of(input logic [31:0] v);
        logic [VLW-1:0] base;
        base = VLW'(VLEN / 8) >> v[4:3];
        case (v[2:0])
            3'b000:  vlmax_of = base;
            3'b001:  vlmax_of = base << 1;
            3'b010:  vlmax_of = base << 2;
            3'b011:  vlmax_of = base << 3;
            3'b101:  vlmax_of = base >> 3;
            3'b110:  vlmax_of = base >> 2;
            3'b111:  vlmax_of = base >> 1;
            default: vlmax_of = '0;
        endcase
    endfunction

    // vl = min(AVL, VLMAX).
    function automatic logic [VLW-1:0] clamp_vl(input logic [XLEN-1:0] avl,
                                                input logic [VLW-1:0]  vlmax);
        if (avl < XLEN'(vlmax)) clamp_vl = VLW'(avl);
        else                    clamp_vl = vlmax;
    endfunction

    // Architectural configuration state
    logic [31:0]    vtype_r;
    logic [VLW-1:0] vl_r;

    // FIFO storage and pointers
    logic [31:0]    mem_bits  [DEPTH];
    logic [XLEN-1:0] mem_rs1  [DEPTH];
    logic [XLEN-1:0] mem_rs2  [DEPTH];
    logic [31:0]    mem_vtype [DEPTH];
    logic [VLW-1:0] mem_vl    [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Decode results
    logic            accept;
    logic            is_vec;
    logic            is_cfg;
    logic            form_vli;
    logic            form_vli_imm;
    logic            form_vl;
    logic            push;
    logic            pop;
    logic            cfg_commit;
    logic            reject;
    logic [31:0]     new_vtype;
    logic [XLEN-1:0] avl;
    logic            keep_vl;
    logic [VLW-1:0]  new_vlmax;
    logic [31:0]     vtype_next;
    logic [VLW-1:0]  vl_next;

    assign insn_ready = (count != CW'(DEPTH));
    assign out_valid  = (count != '0);
    assign accept     = insn_valid && insn_ready;
    assign pop        = out_valid && out_ready;

    // Head entry drives the backend; zero while empty.
    assign out_bits  = out_valid ? mem_bits[rd_ptr]  : '0;
    assign out_rs1   = out_valid ? mem_rs1[rd_ptr]   : '0;
    assign out_rs2   = out_valid ? mem_rs2[rd_ptr]   : '0;
    assign out_vtype = out_valid ? mem_vtype[rd_ptr] : '0;
    assign out_vl    = out_valid ? mem_vl[rd_ptr]    : '0;

    // Classify the incoming instruction and compute the vset result.
    always_comb begin
        is_vec       = 1'b0;
        is_cfg       = 1'b0;
        form_vli     = 1'b0;
        form_vli_imm = 1'b0;
        form_vl      = 1'b0;
        new_vtype    = VILL_VTYPE;
        avl          = '0;
        keep_vl      = 1'b0;
        new_vlmax    = '0;
        vtype_next   = vtype_r;
        vl_next      = vl_r;

        case (insn_bits[6:0])
            OP_LD, OP_ST: is_vec = 1'b1;
            OP_ALU: begin
                if (insn_bits[14:12] == 3'b111) is_cfg = 1'b1;
                else                            is_vec = 1'b1;
            end
            default: ;
        endcase

        form_vli     = !insn_bits[31];
        form_vli_imm = (insn_bits[31:30] == 2'b11);
        form_vl      = insn_bits[31] && (insn_bits[30:25] == 6'b0);

        if (form_vli)          new_vtype = {21'b0, insn_bits[30:20]};
        else if (form_vli_imm) new_vtype = {22'b0, insn_bits[29:20]};
        else                   new_vtype = 32'(insn_rs2);

        if (form_vli_imm)                  avl = XLEN'(insn_bits[19:15]);
        else if (insn_bits[19:15] != 5'd0) avl = insn_rs1;
        else                               avl = '1;

        keep_vl   = !form_vli_imm && (insn_bits[19:15] == 5'd0)
                    && (insn_bits[11:7] == 5'd0);
        new_vlmax = vlmax_of(new_vtype);

        if (!vtype_ok(new_vtype)) begin
            vtype_next = VILL_VTYPE;
            vl_next    = '0;
        end else if (keep_vl) begin
            if (!vtype_r[31] && (new_vlmax == vlmax_of(vtype_r))) begin
                vtype_next = new_vtype;
                vl_next    = vl_r;
            end else begin
                vtype_next = VILL_VTYPE;
                vl_next    = '0;
            end
        end else begin
            vtype_next = new_vtype;
            vl_next    = clamp_vl(avl, new_vlmax);
        end
    end

    assign cfg_commit = accept && is_cfg && (form_vli || form_vli_imm || form_vl);
    assign push       = accept && is_vec && !vtype_r[31];
    assign reject     = accept && !push && !cfg_commit;

    // Configuration registers and one-cycle result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vtype_r      <= VILL_VTYPE;
            vl_r         <= '0;
            cfg_rd_valid <= 1'b0;
            cfg_rd_idx   <= '0;
            cfg_rd_data  <= '0;
            illegal      <= 1'b0;
        end else begin
            cfg_rd_valid <= cfg_commit;
            illegal      <= reject;
            if (cfg_commit) begin
                vtype_r     <= vtype_next;
                vl_r        <= vl_next;
                cfg_rd_idx  <= insn_bits[11:7];
                cfg_rd_data <= XLEN'(vl_next);
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO entry write: instruction plus the pre-update vtype/vl snapshot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_bits[wr_ptr]  <= insn_bits;
            mem_rs1[wr_ptr]   <= insn_rs1;
            mem_rs2[wr_ptr]   <= insn_rs2;
            mem_vtype[wr_ptr] <= vtype_r;
            mem_vl[wr_ptr]    <= vl_r;
        end
    end

endmodule

// File: tb/tb_rvv_inst_issue_buffer.sv
// Directed bench for rvv_inst_issue_buffer (DEPTH=4, VLEN=128, XLEN=32).
module tb_rvv_inst_issue_buffer;

    localparam int DEPTH = 4;
    localparam int VLEN  = 128;
    localparam int XLEN  = 32;
    localparam int VLW   = $clog2(VLEN) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            insn_valid = 1'b0;
    logic            insn_ready;
    logic [31:0]     insn_bits = '0;
    logic [XLEN-1:0] insn_rs1 = '0;
    logic [XLEN-1:0] insn_rs2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_bits;
    logic [XLEN-1:0] out_rs1;
    logic [XLEN-1:0] out_rs2;
    logic [31:0]     out_vtype;
    logic [VLW-1:0]  out_vl;
    logic            cfg_rd_valid;
    logic [4:0]      cfg_rd_idx;
    logic [XLEN-1:0] cfg_rd_data;
    logic            illegal;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_errors = 0;

    rvv_inst_issue_buffer #(.DEPTH(DEPTH), .VLEN(VLEN), .XLEN(XLEN), .VLW(VLW)) dut (
        .clk(clk), .rst(rst),
        .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_bits(insn_bits),
        .insn_rs1(insn_rs1), .insn_rs2(insn_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_vtype(out_vtype), .out_vl(out_vl),
        .cfg_rd_valid(cfg_rd_valid), .cfg_rd_idx(cfg_rd_idx), .cfg_rd_data(cfg_rd_data),
        .illegal(illegal), .count(count)
    );

    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                                input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                                 input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2);
        return {1'b1, 6'b000000, rs2, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_vadd(input logic [4:0] vd);
        return {6'b000000, 1'b1, 5'd2, 5'd1, 3'b000, vd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_vle(input logic [4:0] vd);
        return {3'b000, 1'b0, 2'b00, 1'b1, 5'b00000, 5'd10, 3'b000, vd, 7'b0000111};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle request; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] b, input logic [31:0] r1, input logic [31:0] r2);
        insn_bits  = b;
        insn_rs1   = r1;
        insn_rs2   = r2;
        insn_valid = 1'b1;
        @(posedge clk);
        #1;
        insn_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_insn_ready", insn_ready, 1);
        chk("rst_cfg_valid", cfg_rd_valid, 0);
        chk("rst_cfg_idx", cfg_rd_idx, 0);
        chk("rst_cfg_data", cfg_rd_data, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_out_bits", out_bits, 0);
        chk("rst_out_vl", out_vl, 0);
        rst = 1'b0;

        // vill after reset: vector op dropped
        send(enc_vadd(5'd3), 32'h1, 32'h0);
        chk("rst_vill_illegal", illegal, 1);
        chk("rst_vill_count", count, 0);

        // vsetvli x5, x6(=40), e8,m1 -> vl 16
        send(enc_vsetvli(5'd5, 5'd6, 11'h000), 32'd40, 32'h0);
        chk("vli_cfg_valid", cfg_rd_valid, 1);
        chk("vli_cfg_idx", cfg_rd_idx, 5);
        chk("vli_cfg_data", cfg_rd_data, 16);
        chk("vli_illegal", illegal, 0);
        chk("vli_no_push", count, 0);
        send(enc_vadd(5'd4), 32'hA1, 32'hB2);
        chk("vadd_cfg_pulse_end", cfg_rd_valid, 0);
        chk("vadd_out_valid", out_valid, 1);
        chk("vadd_count", count, 1);
        chk("vadd_bits", out_bits, enc_vadd(5'd4));
        chk("vadd_rs1", out_rs1, 32'hA1);
        chk("vadd_rs2", out_rs2, 32'hB2);
        chk("vadd_vtype", out_vtype, 32'h0);
        chk("vadd_vl", out_vl, 16);
        pop1();
        chk("vadd_pop_count", count, 0);
        chk("vadd_pop_valid", out_valid, 0);

        // vsetivli uimm=3 e32,m8 -> vl 3; vsetvli x1,x0 -> VLMAX 32
        send(enc_vsetivli(5'd2, 5'd3, 10'h013), 32'h0, 32'h0);
        chk("ivli_cfg_idx", cfg_rd_idx, 2);
        chk("ivli_cfg_data", cfg_rd_data, 3);
        send(enc_vsetvli(5'd1, 5'd0, 11'h013), 32'd7, 32'h0);
        chk("vlmax_cfg_idx", cfg_rd_idx, 1);
        chk("vlmax_cfg_data", cfg_rd_data, 32);
        send(enc_vadd(5'd6), 32'h33, 32'h0);
        chk("vlmax_vl", out_vl, 32);
        chk("vlmax_vtype", out_vtype, 32'h13);
        pop1();

        // vsetvli x0,x0 with same VLMAX (e16,m4) keeps vl
        send(enc_vsetvli(5'd0, 5'd0, 11'h00A), 32'd1, 32'h0);
        chk("keep_cfg_valid", cfg_rd_valid, 1);
        chk("keep_cfg_idx", cfg_rd_idx, 0);
        chk("keep_cfg_data", cfg_rd_data, 32);
        send(enc_vadd(5'd6), 32'h44, 32'h0);
        chk("keep_vtype", out_vtype, 32'h0A);
        chk("keep_vl", out_vl, 32);
        pop1();
        // vsetvli x0,x0 with different VLMAX (e8,m1) -> vill
        send(enc_vsetvli(5'd0, 5'd0, 11'h000), 32'd1, 32'h0);
        chk("chg_cfg_data", cfg_rd_data, 0);

        // vsetvl SEW32 with fractional LMUL -> vill
        send(enc_vsetvl(5'd3, 5'd7, 5'd8), 32'd10, 32'h0000_0016);
        chk("vl16_cfg_valid", cfg_rd_valid, 1);
        chk("vl16_cfg_data", cfg_rd_data, 0);
        send(enc_vle(5'd1), 32'h100, 32'h0);
        chk("vle_vill_illegal", illegal, 1);
        chk("vle_vill_count", count, 0);
        chk("vle_vill_cfg", cfg_rd_valid, 0);
        // legal vsetvl e16,m1 with AVL 10 -> vl 8
        send(enc_vsetvl(5'd3, 5'd7, 5'd8), 32'd10, 32'h0000_0008);
        chk("vl08_cfg_data", cfg_rd_data, 8);
        chk("vl08_illegal", illegal, 0);
        // malformed vsetvl (bits[30:25] != 0) rejected, state untouched
        send({1'b1, 6'b000001, 5'd8, 5'd7, 3'b111, 5'd3, 7'b1010111}, 32'd1, 32'h0);
        chk("badvl_illegal", illegal, 1);
        chk("badvl_cfg", cfg_rd_valid, 0);
        send(enc_vle(5'd2), 32'h200, 32'h0);
        chk("vle_push_count", count, 1);
        chk("vle_vtype", out_vtype, 32'h08);
        chk("vle_vl", out_vl, 8);
        chk("vle_bits", out_bits, enc_vle(5'd2));
        pop1();
        // reserved vtype bit -> vill
        send(enc_vsetvl(5'd3, 5'd7, 5'd8), 32'd10, 32'h0000_0100);
        chk("rsv_cfg_data", cfg_rd_data, 0);
        send(enc_vadd(5'd1), 32'h1, 32'h0);
        chk("rsv_illegal", illegal, 1);
        chk("rsv_count", count, 0);

        // Fill FIFO with out_ready low
        send(enc_vsetvli(5'd4, 5'd6, 11'h000), 32'd100, 32'h0);
        chk("fill_cfg_data", cfg_rd_data, 16);
        for (int i = 1; i <= 4; i++) send(enc_vadd(5'd7), 32'(i), 32'h0);
        chk("full_count", count, 4);
        chk("full_ready", insn_ready, 0);
        chk("full_head", out_rs1, 1);
        insn_bits  = enc_vadd(5'd7);
        insn_rs1   = 32'd5;
        insn_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_count", count, 4);
        chk("stall_head", out_rs1, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain1_count", count, 3);
        chk("drain1_head", out_rs1, 2);
        chk("drain1_ready", insn_ready, 1);
        @(posedge clk);
        #1;
        insn_valid = 1'b0;
        chk("drain2_count", count, 3);
        chk("drain2_head", out_rs1, 3);
        @(posedge clk);
        #1;
        chk("drain3_count", count, 2);
        chk("drain3_head", out_rs1, 4);
        @(posedge clk);
        #1;
        chk("drain4_count", count, 1);
        chk("drain4_wrap_head", out_rs1, 5);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain5_count", count, 0);
        chk("drain5_valid", out_valid, 0);

        // Interleaved vector ops and vsetvli, back to back
        send(enc_vsetvli(5'd4, 5'd6, 11'h000), 32'd5, 32'h0);
        chk("pre_cfg_data", cfg_rd_data, 5);
        send(enc_vadd(5'd8), 32'h11, 32'h0);
        send(enc_vsetvli(5'd9, 5'd6, 11'h009), 32'd100, 32'h0);
        chk("mid_cfg_valid", cfg_rd_valid, 1);
        chk("mid_cfg_idx", cfg_rd_idx, 9);
        chk("mid_cfg_data", cfg_rd_data, 16);
        send(enc_vadd(5'd9), 32'h22, 32'h0);
        chk("int_count", count, 2);
        chk("int_e0_rs1", out_rs1, 32'h11);
        chk("int_e0_vl", out_vl, 5);
        chk("int_e0_vtype", out_vtype, 32'h0);
        pop1();
        chk("int_e1_rs1", out_rs1, 32'h22);
        chk("int_e1_vl", out_vl, 16);
        chk("int_e1_vtype_lo", out_vtype[5:0], 6'b001001);
        chk("int_e1_count", count, 1);

        // Non-vector opcode rejected with legal vtype
        send(32'h0020_80B3, 32'h0, 32'h0);
        chk("opc_illegal", illegal, 1);
        chk("opc_count", count, 1);
        send(enc_vadd(5'd10), 32'h55, 32'h0);
        send(enc_vadd(5'd11), 32'h66, 32'h0);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_illegal", illegal, 0);

        // Asynchronous reset mid-operation
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_ready", insn_ready, 1);
        #1;
        rst = 1'b0;
        send(enc_vadd(5'd1), 32'h77, 32'h0);
        chk("arst_vill_illegal", illegal, 1);
        chk("arst_vill_count", count, 0);
        send(32'h0020_80B3, 32'h0, 32'h0);
        chk("arst_opc_illegal", illegal, 1);
        chk("arst_opc_count", count, 0);
        chk("arst_opc_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("illegal_pulse_end", illegal, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
